vga_scroll_scheduler: RTL and testbench
=======================================

Name: vga_scroll_scheduler

Overview:
Sequences the note display. Advances the vertical scroll offset once per video frame. Captures fret/strum presses from the 16 board switches. Grants at most one note spawn per frame to the sprite renderer through a valid/ready handshake, using round-robin arbitration across lanes. Sits between the switch inputs, the frame timing generator and the VGA rendering datapath, and supplies the scroll offset that datapath consumes.

Parameters:
H_LINES, 480, visible lines; scroll offset wraps modulo this value
STEP, 2, lines advanced per frame tick; legal range 1 .. H_LINES-1
LANES, 16, number of switch lanes; fixed at 16 in this revision

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = in reset)
frame_tick  in  1  single-cycle pulse, once per frame at vertical blank
switches  in  16  raw board switches, asynchronous to clk
spawn_ready  in  1  renderer accepts the spawn when high with spawn_valid
offset_out  out  10  current scroll offset, 0 .. H_LINES-1
spawn_valid  out  1  a spawn is offered
spawn_lane  out  4  lane index of the offered spawn
spawn_offset  out  10  offset at which the spawned note is anchored
pending_out  out  16  sticky per-lane request bits

Behaviour:
- Reset (reset=0, asynchronous): offset_out=0, spawn_valid=0, spawn_lane=0, spawn_offset=0, pending=0, last_grant=15, state=IDLE, synchronizer and edge flops=0.
- Switch capture: each switch passes through a 2-flop synchronizer and then a registered rising-edge detect. pending[i] is set 3 cycles after the switch rises.
- Switch held high through reset release: produces one edge, which counts as a press.
- Set and clear of the same lane in the same cycle: set wins.
- Offset: on every sampled frame_tick, in any state, offset <= offset+STEP, minus H_LINES if the sum is >= H_LINES.
- Offset arithmetic is 11 bits internally; no other wrap path exists.
- FSM states: IDLE, ARB, OFFER.
  - IDLE: if frame_tick=1 and pending is nonzero, go to ARB; otherwise stay.
  - ARB (1 cycle): round-robin select the first pending lane searching from last_grant+1 upward, wrapping 15 to 0. Latch spawn_lane. Latch spawn_offset = offset_out (the value already updated by the triggering tick). Go to OFFER.
  - OFFER: spawn_valid=1. spawn_lane and spawn_offset are held stable until acceptance.
  - On spawn_valid && spawn_ready: clear pending[spawn_lane], set last_grant=spawn_lane, deassert spawn_valid the next cycle, go to IDLE.
- Latency: tick sampled at cycle N; offset updated and state=ARB at N+1; spawn_valid=1 at N+2.
- frame_tick during ARB or OFFER: offset still advances; no additional spawn is queued. A maximum of one spawn is made per triggering tick, and ticks during OFFER are dropped for spawning.
- Pending bits for non-granted lanes persist indefinitely; there is no timeout.

Optional Feature:
Macro SCROLL_PAUSE_EN.
- Defined: adds input port pause (1 bit). While pause=1, frame_tick is ignored for both offset advance and spawn triggering. Switch capture continues. An OFFER already in progress completes normally.
- Undefined: no pause port; every frame_tick acts.

Decomposition:
- Package guitar_vga_pkg holds:
  - H_LINES default constant
  - OFFSET_W=10 and LANE_W=4
  - the FSM state enum typedef (IDLE/ARB/OFFER)
- Sub-module rr_arbiter_16: combinational round-robin pick. Inputs: req[15:0], last[3:0]. Outputs: grant_idx[3:0], any.
- Synchronizer and edge detect stay inline.

Test Plan:
1. Reset, no switches, STEP=2, frame_tick every 10 cycles -> offset_out=6 after 3 ticks; 0 after 240 ticks; spawn_valid never asserts.
2. STEP=7 override, 69 ticks -> offset_out=3 (wrap from 483); spawn_offset unaffected.
3. switches=0x0020 pulse -> pending_out=0x0020 three cycles later. Next tick (offset 4 to 6) -> spawn_valid two cycles after the tick, spawn_lane=5, spawn_offset=6. spawn_ready=1 -> pending_out=0x0000, spawn_valid=0 next cycle.
4. Lanes 2 and 9 pending, last_grant=15 -> first tick grants lane 2, second tick grants lane 9. Then with lanes 2 and 10 pending and last_grant=9 -> lane 10 is granted before lane 2.
5. spawn_ready held low across 3 ticks -> spawn_lane and spawn_offset stable, offset_out advances by 6, only one spawn issued, pending unchanged until acceptance.
6. reset driven low mid-OFFER -> spawn_valid=0, offset_out=0, pending_out=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/guitar_vga_pkg.sv
// Shared constants and FSM state type for the note-display scroll scheduler.
package guitar_vga_pkg;

  localparam int H_LINES_DEF = 480;
  localparam int OFFSET_W    = 10;
  localparam int LANE_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    OFFER
  } state_e;

endpackage : guitar_vga_pkg

// File: rtl/rr_arbiter_16.sv
// Combinational round-robin pick over 16 lanes. The search starts at last+1
// and wraps from 15 to 0, so the previous winner has the lowest priority.
module rr_arbiter_16
  import guitar_vga_pkg::*;
(
  input  logic [15:0]       req,
  input  logic [LANE_W-1:0] last,
  output logic [LANE_W-1:0] grant_idx,
  output logic              any
);

  logic [LANE_W-1:0] idx;

  // NOTE: every output and temporary gets a default before the loop, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int i = 1; i <= 16; i++) begin
      // The 4-bit add wraps naturally; i=16 lands back on last itself.
      idx = last + LANE_W'(i);
      if (!any && req[idx]) begin
        grant_idx = idx;
        any       = 1'b1;
      end
    end
  end

endmodule : rr_arbiter_16

// File: rtl/vga_scroll_scheduler.sv
// Scroll offset advance, switch capture and one-spawn-per-frame round-robin
// scheduler. Optional `SCROLL_PAUSE_EN adds a pause input that masks frame_tick.
module vga_scroll_scheduler
  import guitar_vga_pkg::*;
#(
  parameter int H_LINES = H_LINES_DEF,
  parameter int STEP    = 2,
  parameter int LANES   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
`ifdef SCROLL_PAUSE_EN
  input  logic                pause,
`endif
  input  logic [LANES-1:0]    switches,
  input  logic                spawn_ready,
  output logic [OFFSET_W-1:0] offset_out,
  output logic                spawn_valid,
  output logic [LANE_W-1:0]   spawn_lane,
  output logic [OFFSET_W-1:0] spawn_offset,
  output logic [LANES-1:0]    pending_out
);

  logic                tick;
  logic [LANES-1:0]    sync1_q, sync2_q, edge_q, pending_q, pending_d, rise, clr_mask;
  logic [OFFSET_W-1:0] offset_q, offset_d, spawn_offset_q, spawn_offset_d;
  logic [OFFSET_W:0]   sum;
  logic [LANE_W-1:0]   spawn_lane_q, spawn_lane_d, last_grant_q, last_grant_d, grant_idx;
  logic                grant_any, accept;
  state_e              state_q, state_d;

`ifdef SCROLL_PAUSE_EN
  assign tick = frame_tick & ~pause;
`else
  assign tick = frame_tick;
`endif

  rr_arbiter_16 u_arb (
    .req       (pending_q),
    .last      (last_grant_q),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign rise        = sync2_q & ~edge_q;
  assign spawn_valid = (state_q == OFFER);
  assign accept      = spawn_valid & spawn_ready;

  // Offset advances on every tick regardless of scheduler state.
  always_comb begin
    sum      = {1'b0, offset_q} + (OFFSET_W + 1)'(STEP);
    offset_d = offset_q;
    if (tick) begin
      if (sum >= (OFFSET_W + 1)'(H_LINES)) offset_d = sum[OFFSET_W-1:0] - OFFSET_W'(H_LINES);
      else                                 offset_d = sum[OFFSET_W-1:0];
    end
  end

  // A new press on the lane being accepted wins over the clear.
  always_comb begin
    clr_mask  = accept ? (LANES'(1) << spawn_lane_q) : '0;
    pending_d = (pending_q & ~clr_mask) | rise;
  end

  always_comb begin
    state_d        = state_q;
    spawn_lane_d   = spawn_lane_q;
    spawn_offset_d = spawn_offset_q;
    last_grant_d   = last_grant_q;
    case (state_q)
      IDLE: if (tick && |pending_q) state_d = ARB;
      ARB: begin
        // offset_q already holds the value advanced by the triggering tick.
        spawn_lane_d   = grant_idx;
        spawn_offset_d = offset_q;
        state_d        = grant_any ? OFFER : IDLE;
      end
      OFFER: begin
        if (spawn_ready) begin
          last_grant_d = spawn_lane_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      edge_q         <= '0;
      pending_q      <= '0;
      offset_q       <= '0;
      spawn_lane_q   <= '0;
      spawn_offset_q <= '0;
      last_grant_q   <= '1;
      state_q        <= IDLE;
    end else begin
      sync1_q        <= switches;
      sync2_q        <= sync1_q;
      edge_q         <= sync2_q;
      pending_q      <= pending_d;
      offset_q       <= offset_d;
      spawn_lane_q   <= spawn_lane_d;
      spawn_offset_q <= spawn_offset_d;
      last_grant_q   <= last_grant_d;
      state_q        <= state_d;
    end
  end

  assign offset_out   = offset_q;
  assign spawn_lane   = spawn_lane_q;
  assign spawn_offset = spawn_offset_q;
  assign pending_out  = pending_q;

endmodule : vga_scroll_scheduler

// File: tb/tb_vga_scroll_scheduler.sv
// Directed bench for vga_scroll_scheduler: default STEP=2 instance plus a
// STEP=7 instance for the wrap case.
module tb_vga_scroll_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick, tick7;
  logic [15:0] switches;
  logic        spawn_ready;
  logic [9:0]  offset_out, spawn_offset, offset7, spawn_offset7;
  logic        spawn_valid, spawn_valid7;
  logic [3:0]  spawn_lane, spawn_lane7;
  logic [15:0] pending_out, pending7;

  int compared   = 0;
  int mismatched = 0;
  logic phase1   = 1'b0;
  logic sv_seen  = 1'b0;

  always #5 clk = ~clk;

  vga_scroll_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .switches     (switches),
    .spawn_ready  (spawn_ready),
    .offset_out   (offset_out),
    .spawn_valid  (spawn_valid),
    .spawn_lane   (spawn_lane),
    .spawn_offset (spawn_offset),
    .pending_out  (pending_out)
  );

  vga_scroll_scheduler #(.STEP(7)) dut7 (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (tick7),
    .switches     (16'h0000),
    .spawn_ready  (1'b0),
    .offset_out   (offset7),
    .spawn_valid  (spawn_valid7),
    .spawn_lane   (spawn_lane7),
    .spawn_offset (spawn_offset7),
    .pending_out  (pending7)
  );

  always @(negedge clk) if (phase1 && spawn_valid) sv_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One tick on the main instance, then 9 idle cycles.
  task automatic tick_gap();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc(9);
  endtask

  // Tick and advance to the cycle where the offer should be visible.
  task automatic tick_to_offer();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
  endtask

  task automatic accept();
    spawn_ready = 1'b1;
    cyc();
    spawn_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; frame_tick = 1'b0; tick7 = 1'b0;
    switches = '0; spawn_ready = 1'b0;
    cyc(3);
    check("rst_offset",  offset_out,   0);
    check("rst_valid",   spawn_valid,  0);
    check("rst_lane",    spawn_lane,   0);
    check("rst_spoff",   spawn_offset, 0);
    check("rst_pending", pending_out,  0);
    reset = 1'b1;
    cyc(2);

    // 1: plain scrolling, no switches
    phase1 = 1'b1;
    repeat (3) tick_gap();
    check("t1_off_3ticks", offset_out, 6);
    repeat (237) tick_gap();
    check("t1_off_240ticks", offset_out, 0);
    phase1 = 1'b0;
    check("t1_no_spawn", sv_seen, 0);

    // 2: STEP=7 wrap from 483
    repeat (68) begin
      tick7 = 1'b1; cyc(); tick7 = 1'b0; cyc();
    end
    check("t2_off_68", offset7, 476);
    tick7 = 1'b1; cyc(); tick7 = 1'b0; cyc();
    check("t2_off_69", offset7, 3);
    check("t2_spoff", spawn_offset7, 0);
    check("t2_valid", spawn_valid7, 0);

    // 3: single press on lane 5
    repeat (2) tick_gap();
    check("t3_off_pre", offset_out, 4);
    switches = 16'h0020;
    cyc(2);
    check("t3_pend_2cyc", pending_out, 16'h0000);
    cyc();
    check("t3_pend_3cyc", pending_out, 16'h0020);
    switches = 16'h0000;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    check("t3_off_after_tick", offset_out, 6);
    check("t3_valid_arb", spawn_valid, 0);
    cyc();
    check("t3_valid", spawn_valid, 1);
    check("t3_lane", spawn_lane, 5);
    check("t3_spoff", spawn_offset, 6);
    accept();
    check("t3_pend_clr", pending_out, 16'h0000);
    check("t3_valid_drop", spawn_valid, 0);

    // 4: round-robin order
    reset = 1'b0; cyc(); reset = 1'b1; cyc();
    switches = 16'h0204;
    cyc(4);
    switches = 16'h0000;
    check("t4_pend_2_9", pending_out, 16'h0204);
    tick_to_offer();
    check("t4_lane_a", spawn_lane, 2);
    accept();
    check("t4_pend_a", pending_out, 16'h0200);
    tick_to_offer();
    check("t4_lane_b", spawn_lane, 9);
    accept();
    check("t4_pend_b", pending_out, 16'h0000);
    switches = 16'h0404;
    cyc(4);
    switches = 16'h0000;
    check("t4_pend_2_10", pending_out, 16'h0404);
    tick_to_offer();
    check("t4_lane_c", spawn_lane, 10);
    accept();
    tick_to_offer();
    check("t4_lane_d", spawn_lane, 2);
    check("t4_spoff_d", spawn_offset, 8);
    accept();

    // 5: back-pressure across three ticks
    switches = 16'h0080;
    cyc(4);
    switches = 16'h0000;
    tick_to_offer();
    check("t5_valid", spawn_valid, 1);
    check("t5_lane0", spawn_lane, 7);
    check("t5_spoff0", spawn_offset, 10);
    repeat (3) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc(3);
    end
    check("t5_off", offset_out, 16);
    check("t5_lane1", spawn_lane, 7);
    check("t5_spoff1", spawn_offset, 10);
    check("t5_pend_held", pending_out, 16'h0080);
    check("t5_valid_held", spawn_valid, 1);
    accept();
    check("t5_pend_clr", pending_out, 16'h0000);
    cyc(3);
    check("t5_single_spawn", spawn_valid, 0);

    // 6: asynchronous reset mid-offer
    switches = 16'h0008;
    cyc(4);
    switches = 16'h0000;
    tick_to_offer();
    check("t6_valid_pre", spawn_valid, 1);
    check("t6_off_pre", offset_out, 18);
    #2 reset = 1'b0;
    #1;
    check("t6_valid_rst", spawn_valid, 0);
    check("t6_off_rst", offset_out, 0);
    check("t6_pend_rst", pending_out, 16'h0000);
    cyc();
    reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_vga_scroll_scheduler
